// File: rtl/lsu_if.sv
// Data-bus bundle between the load/store unit and memory: one request
// channel and one response channel, each with its own valid/ready handshake.
interface lsu_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: alignment check, single-beat bus access with response
// timeout, load extension, and the four load/store trap pulses.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        done,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic        trap_ld_addr_misaligned,
    output logic        trap_ld_access_fault,
    output logic        trap_st_amo_addr_misaligned,
    output logic        trap_st_amo_access_fault,
    lsu_if.master       bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_e;

    function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] fmt_wstrb(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] lane, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   return {{24{~uns & b[7]}}, b};
            2'b01:   return {{16{~uns & h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] load_data_q, load_data_d;
    logic        req_ready_q, req_ready_d;
    logic        done_q, done_d;
    logic        ld_mis_q, ld_mis_d, ld_af_q, ld_af_d;
    logic        st_mis_q, st_mis_d, st_af_q, st_af_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;

    logic        accept_s;
    logic        misalign_s;
    logic [31:0] cnt_inc_s;
    logic        timeout_s;

    assign accept_s   = req_valid && req_ready_q && (is_load ^ is_store);
    assign misalign_s = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign cnt_inc_s  = cnt_q + 32'd1;
    // A zero limit disables the timeout entirely.
    assign timeout_s  = (TIMEOUT_CYCLES != 32'd0) && (cnt_inc_s >= TIMEOUT_CYCLES);

    // Next-state, capture and trap decode; trap pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        size_d      = size_q;
        uns_d       = uns_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        load_data_d = load_data_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        ld_mis_d    = 1'b0;
        ld_af_d     = 1'b0;
        st_mis_d    = 1'b0;
        st_af_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    store_d     = is_store;
                    size_d      = funct3[1:0];
                    uns_d       = funct3[2];
                    mem_addr_d  = addr;
                    bus_we_d    = is_store;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = fmt_wdata(funct3[1:0], store_data);
                    bus_wstrb_d = is_store ? fmt_wstrb(funct3[1:0], addr[1:0]) : 4'b0000;
                    if (funct3[1:0] == 2'b11) begin
                        state_d     = S_DONE;
                        load_data_d = 32'd0;
                        ld_af_d     = is_load;
                        st_af_d     = is_store;
                    end else if (misalign_s) begin
                        state_d     = S_DONE;
                        load_data_d = 32'd0;
                        ld_mis_d    = is_load;
                        st_mis_d    = is_store;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = 32'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc_s;
                if (timeout_s) begin
                    state_d     = S_DONE;
                    load_data_d = 32'd0;
                    ld_af_d     = ~store_q;
                    st_af_d     = store_q;
                end else if (bus.bus_req_ready) begin
                    state_d = S_RSP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RSP: begin
                cnt_d = cnt_inc_s;
                // A response in the timeout cycle still counts as a normal completion.
                if (bus.bus_rsp_valid) begin
                    state_d = S_DONE;
                    if (bus.bus_rsp_err) begin
                        load_data_d = 32'd0;
                        ld_af_d     = ~store_q;
                        st_af_d     = store_q;
                    end else begin
                        load_data_d = store_q ? 32'd0
                                              : fmt_load(size_q, uns_q, mem_addr_q[1:0], bus.bus_rsp_rdata);
                    end
                end else if (timeout_s) begin
                    state_d     = S_DONE;
                    load_data_d = 32'd0;
                    ld_af_d     = ~store_q;
                    st_af_d     = store_q;
                end else begin
                    state_d = S_RSP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d     = (state_d == S_IDLE);
        bus_req_valid_d = (state_d == S_REQ);
        done_d          = (state_d == S_DONE);
    end

    // State and registered outputs; reset returns to IDLE with req_ready high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            store_q         <= 1'b0;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            cnt_q           <= 32'd0;
            mem_addr_q      <= 32'd0;
            load_data_q     <= 32'd0;
            req_ready_q     <= 1'b1;
            done_q          <= 1'b0;
            ld_mis_q        <= 1'b0;
            ld_af_q         <= 1'b0;
            st_mis_q        <= 1'b0;
            st_af_q         <= 1'b0;
            bus_req_valid_q <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_addr_q      <= 32'd0;
            bus_wdata_q     <= 32'd0;
            bus_wstrb_q     <= 4'b0000;
        end else begin
            state_q         <= state_d;
            store_q         <= store_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            cnt_q           <= cnt_d;
            mem_addr_q      <= mem_addr_d;
            load_data_q     <= load_data_d;
            req_ready_q     <= req_ready_d;
            done_q          <= done_d;
            ld_mis_q        <= ld_mis_d;
            ld_af_q         <= ld_af_d;
            st_mis_q        <= st_mis_d;
            st_af_q         <= st_af_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_we_q        <= bus_we_d;
            bus_addr_q      <= bus_addr_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_wstrb_q     <= bus_wstrb_d;
        end
    end

    assign req_ready                   = req_ready_q;
    assign done                        = done_q;
    assign load_data                   = load_data_q;
    assign mem_addr                    = mem_addr_q;
    assign trap_ld_addr_misaligned     = ld_mis_q;
    assign trap_ld_access_fault        = ld_af_q;
    assign trap_st_amo_addr_misaligned = st_mis_q;
    assign trap_st_amo_access_fault    = st_af_q;
    assign bus.bus_req_valid           = bus_req_valid_q;
    assign bus.bus_we                  = bus_we_q;
    assign bus.bus_addr                = bus_addr_q;
    assign bus.bus_wdata               = bus_wdata_q;
    assign bus.bus_wstrb               = bus_wstrb_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the rv32i core. It accepts one decoded load or store from execute, checks alignment, and runs a single-beat transaction on the data bus with a response timeout. It returns extended load data and reports completion. It also produces `mem_addr` and the four load/store trap pulses that `zicsr` consumes to update mcause, mtval and mepc.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in REQ+RSP before an access fault is raised; 0 disables the timeout.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: execute presents a memory op.
- `req_ready` out 1: LSU can accept; high only in IDLE.
- `is_load`, `is_store` in 1 each: op type; a request is accepted only if exactly one is set.
- `funct3` in 3: bits [1:0] give size (00 byte, 01 half, 10 word, 11 invalid); bit 2 set means unsigned load.
- `addr` in 32: effective byte address.
- `store_data` in 32: rs2 value.
- `done` out 1: one-cycle completion pulse, success or trap.
- `load_data` out 32: extended load result, valid with `done`.
- `mem_addr` out 32: registered `addr` of the last accepted request.
- `trap_ld_addr_misaligned`, `trap_ld_access_fault`, `trap_st_amo_addr_misaligned`, `trap_st_amo_access_fault` out 1 each: asserted only together with `done`.
- `bus_req_valid` out 1, `bus_req_ready` in 1: request handshake.
- `bus_we` out 1: write request.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32, `bus_wstrb` out 4: write data and byte strobes.
- `bus_rsp_valid` in 1, `bus_rsp_rdata` in 32, `bus_rsp_err` in 1: response.

## Operation
- States: IDLE, REQ, RSP, DONE.
- **IDLE**
  - Accept on `req_valid && req_ready && (is_load ^ is_store)`.
  - On accept, capture op, size, sign, `addr`, `mem_addr`, and the formatted write data/strobes.
  - Misaligned access goes to DONE with the misaligned trap for the op type:
    - half with `addr[0]=1`;
    - word with `addr[1:0]!=0`.
  - Size 11 goes to DONE with the access-fault trap for the op type.
  - Any other accepted request goes to REQ.
  - Trap paths issue no bus transaction.
- **REQ**: `bus_req_valid=1`, with address/data/strobe held stable. When `bus_req_ready=1`, go to RSP.
- **RSP**: on `bus_rsp_valid`, go to DONE.
  - Without `bus_rsp_err`: capture the formatted load data.
  - With `bus_rsp_err`: raise the access fault for the op type and set `load_data=0`.
  - A response is only sampled in RSP.
- **Timeout**
  - The counter clears on entering REQ and increments every cycle in REQ or RSP.
  - When it reaches `TIMEOUT_CYCLES` with no response, go to DONE with the access fault and drop `bus_req_valid`.
  - A response arriving in the same cycle as the timeout wins.
  - Late responses in IDLE/DONE are ignored.
- **DONE**: `done=1` for one cycle with the trap flags, then IDLE.
- **Store formatting**
  - Byte: `wdata={4{sd[7:0]}}`, `wstrb=4'b0001<<addr[1:0]`.
  - Half: `wdata={2{sd[15:0]}}`, `wstrb=4'b0011<<addr[1:0]`.
  - Word: `wdata=sd`, `wstrb=4'b1111`.
  - Loads drive `wstrb=0`.
- **Load formatting**
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`.
  - Sign-extend when `funct3[2]=0`, zero-extend otherwise.
  - Stores and traps give `load_data=0`.
- `load_data` and `mem_addr` hold until the next update.

## Timing
- Reset: state IDLE; `req_ready=1`; all other outputs 0; counter 0.
- Misaligned or invalid: accept in cycle N, `done` in N+1.
- Zero-wait bus: accept N, REQ handshake N+1, response N+2, `done` N+3. Each wait cycle adds one.
- Back-to-back: next accept is possible in the cycle after `done`, so throughput is at most one op per 4 cycles.
- Reset asserted mid-operation: all outputs clear immediately, with no `done` and no trap. An in-flight bus response after reset is ignored.
- `req_valid` with both or neither of `is_load`/`is_store` is not accepted, and `req_ready` stays 1.

## Test plan
- Load byte, signed and unsigned: lb at 0x1003 with rdata 0x80FF_FF7F gives `load_data=0xFFFF_FF80`; lbu gives 0x0000_0080. `done` arrives 3 cycles after accept.
- Store half at 0x2002 with `store_data=0x1234_ABCD`: `bus_addr=0x2000`, `wstrb=4'b1100`, `wdata=0xABCD_ABCD`, `bus_we=1`, no traps.
- Misaligned: lw at 0x1001 gives `done`+`trap_ld_addr_misaligned` in the next cycle with `mem_addr=0x1001`. sh at 0x3 gives `trap_st_amo_addr_misaligned`. `bus_req_valid` never rises in either case.
- Bus stalls and error:
  - `bus_req_ready` held low 5 cycles, then a response: completes normally.
  - `bus_rsp_err=1` on a load gives `trap_ld_access_fault`, `load_data=0`.
- Timeout with `TIMEOUT_CYCLES=4`, bus silent: `trap_st_amo_access_fault` with `done` after 4 cycles in REQ/RSP. A response arriving afterwards is ignored.
- `rst_n` pulsed low while in RSP: `bus_req_valid`, `done` and traps are 0 immediately, and `req_ready=1` after release.
